goldschmidt_div: RTL and testbench

GOLDSCHMIDT_DIV -- requirements
Module: goldschmidt_div

---
 rtl/goldschmidt_div.sv | 133 +++++++++++++
 tb/tb_goldschmidt_div.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_div.sv
// Goldschmidt divider: q = N / D in unsigned Q1.(WIDTH-1) fixed point.
// One shared WIDTH x WIDTH multiplier alternates between scaling the
// numerator (ITER_N) and the denominator (ITER_D). Each pass drives d
// toward 1.0, so n converges toward N/D.
module goldschmidt_div #(
    parameter int WIDTH = 16,
    parameter int ITERS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rnd,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] IA,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        ITER_N,
        ITER_D,
        ROUND,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]   n, d, k;
    logic [3:0]         cnt;
    logic [3:0]         cnt_inc;
    logic               last_iter;
    logic               guard;
    logic               rnd_r;
    logic               accept;
    logic               d_norm;

    logic [WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   trunc_p;
    logic [WIDTH:0]     round_sum;

    assign d_norm    = D[WIDTH-1];
    assign accept    = (state == IDLE) && start;
    assign cnt_inc   = cnt + 4'd1;
    assign last_iter = (cnt_inc == 4'(ITERS));

    // Shared multiplier: numerator in ITER_N, denominator in ITER_D, always by k.
    assign mul_a     = (state == ITER_D) ? d : n;
    assign prod      = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, k};
    // Product is Q2.(2W-2); drop back to Q1.(W-1), saturating when the integer part reaches 2.
    assign trunc_p   = prod[2*WIDTH-1] ? '1 : prod[2*WIDTH-2:WIDTH-1];
    assign round_sum = {1'b0, n} + {{WIDTH{1'b0}}, (rnd_r & guard)};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = d_norm ? ITER_N : DONE;
            end
            ITER_N: state_nx = ITER_D;
            ITER_D: state_nx = last_iter ? ROUND : ITER_N;
            ROUND:  state_nx = DONE;
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration updates, final rounding.
    always_ff @(posedge clk) begin
        if (reset) begin
            n     <= '0;
            d     <= '0;
            k     <= '0;
            cnt   <= '0;
            guard <= 1'b0;
            rnd_r <= 1'b0;
            q     <= '0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (d_norm) begin
                            n     <= N;
                            d     <= D;
                            k     <= IA;
                            rnd_r <= rnd;
                            cnt   <= '0;
                            guard <= 1'b0;
                        end else begin
                            err <= 1'b1;
                            q   <= '1;
                        end
                    end
                end
                ITER_N: begin
                    n     <= trunc_p;
                    guard <= prod[WIDTH-2];
                end
                ITER_D: begin
                    // Next factor is 2 - d, i.e. the two's complement of the new d.
                    d   <= trunc_p;
                    k   <= (~trunc_p) + {{(WIDTH-1){1'b0}}, 1'b1};
                    cnt <= cnt_inc;
                end
                ROUND: begin
                    q   <= round_sum[WIDTH] ? '1 : round_sum[WIDTH-1:0];
                    err <= 1'b0;
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_goldschmidt_div.sv
// Directed bench for goldschmidt_div (WIDTH=16, ITERS=3) with hand-computed results.
module tb_goldschmidt_div;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic         rnd;
    logic [W-1:0] N;
    logic [W-1:0] D;
    logic [W-1:0] IA;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic         err;

    int vectors;
    int miscompares;

    goldschmidt_div #(.WIDTH(16), .ITERS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rnd   (rnd),
        .N     (N),
        .D     (D),
        .IA    (IA),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one edge (the accepting edge).
    task automatic do_start(input logic [W-1:0] n_i, input logic [W-1:0] d_i,
                            input logic [W-1:0] ia_i, input logic r_i);
        N     = n_i;
        D     = d_i;
        IA    = ia_i;
        rnd   = r_i;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int edges, output logic seen);
        edges = 0;
        while (!done && edges < 40) begin
            step();
            edges++;
        end
        seen = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        N = 16'hC000; D = 16'h8000; IA = 16'h8000; rnd = 1'b0;
        step();
        step();
        start = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (q !== 16'h0000) begin miscompares++; $display("FAIL reset_q got %h want 0000", q); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int   edges;
        logic seen;
        do_start(16'hC000, 16'h8000, 16'h8000, 1'b0);
        wait_done(edges, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL basic_done_seen got %b want 1", seen); end
        vectors++; if (edges != 7) begin miscompares++; $display("FAIL basic_latency got %0d want 7", edges); end
        vectors++; if (q !== 16'hC000) begin miscompares++; $display("FAIL basic_q got %h want c000", q); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", err); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_idle got %b want 0", busy); end
        N = 16'h1234; D = 16'h0000; IA = 16'hFFFF;
        step(); step(); step();
        vectors++; if (q !== 16'hC000) begin miscompares++; $display("FAIL basic_q_hold got %h want c000", q); end
    endtask

    task automatic test_err();
        int   edges;
        logic seen;
        logic [W-1:0] dvals [2];
        dvals[0] = 16'h0000;
        dvals[1] = 16'h7FFF;
        for (int i = 0; i < 2; i++) begin
            do_start(16'hC000, dvals[i], 16'h8000, 1'b0);
            wait_done(edges, seen);
            vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL err_done_seen[%0d] got %b want 1", i, seen); end
            // done is already high in the cycle right after the accepting edge
            vectors++; if (edges != 0) begin miscompares++; $display("FAIL err_latency[%0d] got %0d want 0", i, edges); end
            vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_flag[%0d] got %b want 1", i, err); end
            vectors++; if (q !== 16'hFFFF) begin miscompares++; $display("FAIL err_q[%0d] got %h want ffff", i, q); end
            step();
            step();
            vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_hold[%0d] got %b want 1", i, err); end
        end
    endtask

    task automatic test_round();
        int   edges;
        int   busy_cycles;
        logic seen;
        do_start(16'h8000, 16'hC000, 16'h5555, 1'b1);
        busy_cycles = 0;
        edges = 0;
        while (!done && edges < 40) begin
            if (busy === 1'b1) busy_cycles++;
            step();
            edges++;
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL round_done_seen got %b want 1", done); end
        vectors++; if (busy_cycles != 7) begin miscompares++; $display("FAIL round_busy_cycles got %0d want 7", busy_cycles); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL round_busy_in_done got %b want 1", busy); end
        vectors++; if (q !== 16'h5556) begin miscompares++; $display("FAIL round_q got %h want 5556", q); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL round_err_clear got %b want 0", err); end
        step();
        do_start(16'h8000, 16'hC000, 16'h5555, 1'b0);
        wait_done(edges, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL trunc_done_seen got %b want 1", seen); end
        vectors++; if (q !== 16'h5555) begin miscompares++; $display("FAIL trunc_q got %h want 5555", q); end
        step();
    endtask

    task automatic test_saturate();
        int   edges;
        logic seen;
        logic [W-1:0] ia_v [3];
        logic         r_v  [3];
        logic [W-1:0] q_v  [3];
        ia_v[0] = 16'h8001; r_v[0] = 1'b1; q_v[0] = 16'hFFFF;
        ia_v[1] = 16'h8001; r_v[1] = 1'b0; q_v[1] = 16'hFFFE;
        // final n saturates to ffff with guard=1: rounding must not wrap to 0000
        ia_v[2] = 16'h7FFF; r_v[2] = 1'b1; q_v[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            do_start(16'hFFFF, 16'h8000, ia_v[i], r_v[i]);
            wait_done(edges, seen);
            vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL sat_done_seen[%0d] got %b want 1", i, seen); end
            vectors++; if (q !== q_v[i]) begin miscompares++; $display("FAIL sat_q[%0d] got %h want %h", i, q, q_v[i]); end
            step();
        end
    endtask

    task automatic test_busy_ignore();
        int           dones;
        int           done_edge;
        logic [W-1:0] q_at_done;
        logic         err_at_done;
        dones = 0; done_edge = -1; q_at_done = '0; err_at_done = 1'b0;
        do_start(16'hC000, 16'h8000, 16'h8000, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            if (done === 1'b1) begin
                dones++;
                if (done_edge < 0) begin
                    done_edge   = i - 1;
                    q_at_done   = q;
                    err_at_done = err;
                end
            end
            if (i <= 5) begin
                start = (i % 2 == 1);
                N     = 16'hFFFF;
                D     = 16'h0000;
                IA    = 16'h1234;
                rnd   = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        vectors++; if (dones != 1) begin miscompares++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        vectors++; if (done_edge != 7) begin miscompares++; $display("FAIL ignore_latency got %0d want 7", done_edge); end
        vectors++; if (q_at_done !== 16'hC000) begin miscompares++; $display("FAIL ignore_q got %h want c000", q_at_done); end
        vectors++; if (err_at_done !== 1'b0) begin miscompares++; $display("FAIL ignore_err got %b want 0", err_at_done); end
    endtask

    task automatic test_back_to_back();
        int   e1, e2;
        logic s1, s2;
        N = 16'hC000; D = 16'h8000; IA = 16'h8000; rnd = 1'b0;
        start = 1'b1;
        step();
        wait_done(e1, s1);
        step();
        wait_done(e2, s2);
        start = 1'b0;
        vectors++; if (s1 !== 1'b1 || e1 != 7) begin miscompares++; $display("FAIL b2b_first got seen=%b edges=%0d want seen=1 edges=7", s1, e1); end
        // next accept is the edge after IDLE returns; done-to-done spacing is 9
        vectors++; if (s2 !== 1'b1 || e2 + 1 != 9) begin miscompares++; $display("FAIL b2b_period got seen=%b period=%0d want seen=1 period=9", s2, e2 + 1); end
        vectors++; if (q !== 16'hC000) begin miscompares++; $display("FAIL b2b_q got %h want c000", q); end
        step();
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_no_third got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int   edges;
        int   dones;
        logic seen;
        do_start(16'hC000, 16'h8000, 16'h8000, 1'b0);
        step(); step(); step();
        // now in ITER_D of the second iteration
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_done got %b want 0", done); end
        vectors++; if (q !== 16'h0000) begin miscompares++; $display("FAIL mid_reset_q got %h want 0000", q); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL mid_reset_err got %b want 0", err); end
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        vectors++; if (dones != 0) begin miscompares++; $display("FAIL mid_reset_stray_done got %0d want 0", dones); end
        do_start(16'hC000, 16'h8000, 16'h8000, 1'b0);
        wait_done(edges, seen);
        vectors++; if (seen !== 1'b1 || edges != 7) begin miscompares++; $display("FAIL mid_reset_rerun got seen=%b edges=%0d want seen=1 edges=7", seen, edges); end
        vectors++; if (q !== 16'hC000) begin miscompares++; $display("FAIL mid_reset_q_rerun got %h want c000", q); end
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0; start = 1'b0; rnd = 1'b0;
        N = '0; D = '0; IA = '0;
        test_reset();
        test_basic();
        test_err();
        test_round();
        test_saturate();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
